// File: rtl/riscv_pkg.sv
// Shared core package: data-memory op encoding, access FSM states and
// lane-steering helpers used by dm_access_unit and dm_load_extend.
package riscv_pkg;

  typedef enum logic [2:0] {
    MemB  = 3'b000,
    MemH  = 3'b001,
    MemW  = 3'b010,
    MemBU = 3'b100,
    MemHU = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  // Unused codes (011/110/111) behave as full-word accesses.
  function automatic mem_op_e dm_norm_op(input logic [2:0] code);
    case (code)
      3'b000:  return MemB;
      3'b001:  return MemH;
      3'b100:  return MemBU;
      3'b101:  return MemHU;
      default: return MemW;
    endcase
  endfunction

  // Byte strobes for a store; halfwords pick the half addressed by addr[1].
  function automatic logic [3:0] dm_wstrb(input mem_op_e op, input logic [1:0] addr_lo);
    case (op)
      MemB, MemBU: return 4'b0001 << addr_lo;
      MemH, MemHU: return 4'b0011 << {addr_lo[1], 1'b0};
      default:     return 4'b1111;
    endcase
  endfunction

  // Replicate the LSB-justified store data onto every lane it may occupy.
  function automatic logic [31:0] dm_wdata(input mem_op_e op, input logic [31:0] data);
    case (op)
      MemB, MemBU: return {4{data[7:0]}};
      MemH, MemHU: return {2{data[15:0]}};
      default:     return data;
    endcase
  endfunction

  // Natural-alignment check for halfword and word accesses.
  function automatic logic dm_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
    case (op)
      MemH, MemHU: return addr_lo[0];
      MemW:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_unit_load_extend.sv
// dm_load_extend: picks the addressed byte/half out of a raw bus word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module dm_load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension chosen by the op code.
  always_comb begin
    case (i_addr_lo)
      2'd0:    byte_sel = i_word[7:0];
      2'd1:    byte_sel = i_word[15:8];
      2'd2:    byte_sel = i_word[23:16];
      default: byte_sel = i_word[31:24];
    endcase
    half_sel = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    case (dm_norm_op(i_op))
      MemB:    o_data = {{24{byte_sel[7]}}, byte_sel};
      MemBU:   o_data = {24'd0, byte_sel};
      MemH:    o_data = {{16{half_sel[15]}}, half_sel};
      MemHU:   o_data = {16'd0, half_sel};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: single-outstanding data-memory access engine between the
// execute unit and a valid/ready request/response memory bus. Handles store
// lane steering, load extension and an optional access timeout.
// Optional feature: define DM_MISALIGN_TRAP_EN to fault misaligned H/HU/W
// accesses in IDLE instead of issuing them to the bus.
module dm_access_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_eu_dm_req,
  input  logic        i_eu_dm_wvalid,
  input  logic [2:0]  i_eu_dm_op_data,
  input  logic [31:0] i_eu_dm_addr,
  input  logic [31:0] i_eu_dm_wdata,
  output logic        o_eu_dm_busy,
  output logic        o_eu_dm_done,
  output logic [31:0] o_eu_dm_rdata,
  output logic        o_eu_dm_fault,
  output logic        o_bus_avalid,
  input  logic        i_bus_aready,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_write,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wstrb,
  input  logic        i_bus_bvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_bus_bready
);

  dm_state_e   state_q, state_d;
  logic        wvalid_q, wvalid_d;
  mem_op_e     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  logic [31:0] load_ext;
  logic        timeout_hit;
  logic        misalign;

  dm_load_extend u_load_extend (
    .i_op      (op_q),
    .i_addr_lo (addr_q[1:0]),
    .i_word    (i_bus_rdata),
    .o_data    (load_ext)
  );

`ifdef DM_MISALIGN_TRAP_EN
  assign misalign = dm_misaligned(dm_norm_op(i_eu_dm_op_data), i_eu_dm_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // The count reaches TIMEOUT on the edge ending this cycle.
  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign timeout_hit = (cnt_q + 32'd1) == TIMEOUT;
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // State and datapath registers; reset drops any access in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      wvalid_q <= 1'b0;
      op_q     <= MemB;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      cnt_q    <= 32'd0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wvalid_q <= wvalid_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state logic: accept, handshake, complete or abort.
  always_comb begin
    state_d  = state_q;
    wvalid_d = wvalid_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_eu_dm_req) begin
          if (misalign) begin
            fault_d = 1'b1;
          end else begin
            wvalid_d = i_eu_dm_wvalid;
            op_d     = dm_norm_op(i_eu_dm_op_data);
            addr_d   = i_eu_dm_addr;
            wdata_d  = i_eu_dm_wdata;
            cnt_d    = 32'd0;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 32'd1;
        if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else if (i_bus_aready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 32'd1;
        // A response in the timeout cycle still completes the access.
        if (i_bus_bvalid) begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (!wvalid_q) begin
            rdata_d = load_ext;
          end
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_eu_dm_busy  = state_q != IDLE;
  assign o_eu_dm_done  = done_q;
  assign o_eu_dm_fault = fault_q;
  assign o_eu_dm_rdata = rdata_q;
  assign o_bus_avalid  = state_q == REQ;
  assign o_bus_bready  = state_q == RESP;
  assign o_bus_addr    = {addr_q[31:2], 2'b00};
  assign o_bus_write   = wvalid_q;
  assign o_bus_wdata   = dm_wdata(op_q, wdata_q);
  assign o_bus_wstrb   = wvalid_q ? dm_wstrb(op_q, addr_q[1:0]) : 4'b0000;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: directed vector table, randomized accesses
// against a behavioural model, and hand sequences for reset and timeout.
module tb_dm_access_unit;

  localparam int TO2 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (default timeout)
  logic        req = 0, wv = 0, aready = 0, bvalid = 0;
  logic [2:0]  op = 0;
  logic [31:0] addr = 0, wd = 0, brdata = 0;
  logic        busy, done, fault, avalid, bwrite, bready;
  logic [31:0] rdata, baddr, bwdata;
  logic [3:0]  bwstrb;

  // Short-timeout DUT
  logic        req2 = 0, wv2 = 0, aready2 = 0, bvalid2 = 0;
  logic [2:0]  op2 = 0;
  logic [31:0] addr2 = 0, wd2 = 0, brdata2 = 0;
  logic        busy2, done2, fault2, avalid2, bwrite2, bready2;
  logic [31:0] rdata2, baddr2, bwdata2;
  logic [3:0]  bwstrb2;

  dm_access_unit #(.TIMEOUT(255)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_eu_dm_req(req), .i_eu_dm_wvalid(wv), .i_eu_dm_op_data(op),
    .i_eu_dm_addr(addr), .i_eu_dm_wdata(wd),
    .o_eu_dm_busy(busy), .o_eu_dm_done(done), .o_eu_dm_rdata(rdata), .o_eu_dm_fault(fault),
    .o_bus_avalid(avalid), .i_bus_aready(aready), .o_bus_addr(baddr), .o_bus_write(bwrite),
    .o_bus_wdata(bwdata), .o_bus_wstrb(bwstrb), .i_bus_bvalid(bvalid), .i_bus_rdata(brdata),
    .o_bus_bready(bready)
  );

  dm_access_unit #(.TIMEOUT(TO2)) dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_eu_dm_req(req2), .i_eu_dm_wvalid(wv2), .i_eu_dm_op_data(op2),
    .i_eu_dm_addr(addr2), .i_eu_dm_wdata(wd2),
    .o_eu_dm_busy(busy2), .o_eu_dm_done(done2), .o_eu_dm_rdata(rdata2), .o_eu_dm_fault(fault2),
    .o_bus_avalid(avalid2), .i_bus_aready(aready2), .o_bus_addr(baddr2), .o_bus_write(bwrite2),
    .o_bus_wdata(bwdata2), .o_bus_wstrb(bwstrb2), .i_bus_bvalid(bvalid2), .i_bus_rdata(brdata2),
    .o_bus_bready(bready2)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl_rdata = 0;
  logic [31:0] mdl_rdata2 = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [2:0] m_norm(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd1 || o == 3'd4 || o == 3'd5) return o;
    return 3'd2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w);
    logic [2:0]  n;
    logic [31:0] v;
    n = m_norm(o);
    if (n == 3'd0 || n == 3'd4) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (n == 3'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (n == 3'd1 || n == 3'd5) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (n == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] o, input logic [31:0] w);
    logic [2:0] n;
    n = m_norm(o);
    if (n == 3'd0 || n == 3'd4) return (w & 32'hFF) * 32'h0101_0101;
    if (n == 3'd1 || n == 3'd5) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [3:0] m_strb(input logic wr, input logic [2:0] o, input logic [31:0] a);
    logic [2:0] n;
    n = m_norm(o);
    if (!wr) return 4'd0;
    if (n == 3'd0 || n == 3'd4) return 4'(1 << a[1:0]);
    if (n == 3'd1 || n == 3'd5) return 4'(3 << (2 * a[1]));
    return 4'hF;
  endfunction

  function automatic logic m_trap(input logic [2:0] o, input logic [31:0] a);
`ifdef DM_MISALIGN_TRAP_EN
    logic [2:0] n;
    n = m_norm(o);
    if (n == 3'd1 || n == 3'd5) return a[0];
    if (n == 3'd2) return a[1:0] != 2'd0;
    return 1'b0;
`else
    return 1'b0 & o[0] & a[0];
`endif
  endfunction

  // One access on the main DUT; starts and ends on a falling edge.
  task automatic do_txn(input string nm, input logic wr, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] word, input logic [31:0] exp_r,
                        input logic [31:0] exp_bw, input logic [3:0] exp_s, input int adly, input int bdly);
    $display("txn %s wr=%0b op=%0d addr=%08h wdata=%08h word=%08h adly=%0d bdly=%0d",
             nm, wr, o, a, w, word, adly, bdly);
    req = 1; wv = wr; op = o; addr = a; wd = w;
    @(negedge clk);
    req = 0; addr = $urandom; wd = $urandom; wv = ~wr;
    if (m_trap(o, a)) begin
      chk({nm, "_trap"}, {busy, avalid, bready, done, fault}, 5'b00001);
      return;
    end
    for (int c = 0; c <= adly; c++) begin
      chk({nm, "_req_stat"}, {busy, avalid, bready, done, fault}, 5'b11000);
      chk({nm, "_req_addr"}, baddr, {a[31:2], 2'b00});
      chk({nm, "_req_write"}, bwrite, wr);
      chk({nm, "_req_wstrb"}, bwstrb, exp_s);
      if (wr) chk({nm, "_req_wdata"}, bwdata, exp_bw);
      aready = (c == adly);
      @(negedge clk);
    end
    aready = 0;
    for (int c = 0; c <= bdly; c++) begin
      chk({nm, "_resp_stat"}, {busy, avalid, bready, done, fault}, 5'b10100);
      bvalid = (c == bdly);
      brdata = (c == bdly) ? word : $urandom;
      @(negedge clk);
    end
    bvalid = 0;
    if (!wr) mdl_rdata = exp_r;
    chk({nm, "_done_stat"}, {busy, avalid, bready, done, fault}, 5'b00010);
    chk({nm, "_rdata"}, rdata, mdl_rdata);
  endtask

  // One load on the short-timeout DUT; bcyc = cycle after req carrying bvalid, 0 = never.
  task automatic t2_txn(input string nm, input int bcyc, input logic [31:0] word);
    int   fin;
    logic resp;
    resp = (bcyc != 0) && (bcyc <= TO2);
    fin  = resp ? bcyc + 1 : TO2 + 1;
    $display("txn %s timeout=%0d bvalid_cycle=%0d word=%08h", nm, TO2, bcyc, word);
    req2 = 1; wv2 = 0; op2 = 3'b010; addr2 = 32'h40;
    @(negedge clk);
    req2 = 0;
    for (int c = 1; c <= fin; c++) begin
      if (c < fin) begin
        chk({nm, "_busy"}, {busy2, done2, fault2}, 3'b100);
      end else if (resp) begin
        mdl_rdata2 = word;
        chk({nm, "_done"}, {busy2, done2, fault2}, 3'b010);
        chk({nm, "_rdata"}, rdata2, mdl_rdata2);
      end else begin
        chk({nm, "_fault"}, {busy2, done2, fault2}, 3'b001);
        chk({nm, "_rdata_kept"}, rdata2, mdl_rdata2);
      end
      aready2 = (c == 1);
      bvalid2 = (c == bcyc);
      brdata2 = word;
      if (c < fin) @(negedge clk);
    end
    aready2 = 0;
    bvalid2 = 0;
  endtask

  typedef struct {
    string       nm;
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    logic [31:0] exp_r;
    logic [31:0] exp_bw;
    logic [3:0]  exp_s;
    int          adly;
    int          bdly;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{"lb",      1'b0, 3'b000, 32'h1003, 32'h0,        32'h80FF_1234, 32'hFFFF_FF80, 32'h0,         4'h0, 0, 0};
    vt[1]  = '{"lbu",     1'b0, 3'b100, 32'h1003, 32'h0,        32'h80FF_1234, 32'h0000_0080, 32'h0,         4'h0, 0, 0};
    vt[2]  = '{"sh",      1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 32'h0,        32'h0,         32'hBEEF_BEEF, 4'hC, 0, 0};
    vt[3]  = '{"lh_hi",   1'b0, 3'b001, 32'h1002, 32'h0,        32'h80FF_1234, 32'hFFFF_80FF, 32'h0,         4'h0, 1, 0};
    vt[4]  = '{"lhu_lo",  1'b0, 3'b101, 32'h1000, 32'h0,        32'h80FF_1234, 32'h0000_1234, 32'h0,         4'h0, 0, 2};
    vt[5]  = '{"sb_bp",   1'b1, 3'b000, 32'h3001, 32'h1234_5678, 32'h0,        32'h0,         32'h7878_7878, 4'h2, 5, 3};
    vt[6]  = '{"lw",      1'b0, 3'b010, 32'h1000, 32'h0,        32'h80FF_1234, 32'h80FF_1234, 32'h0,         4'h0, 2, 1};
    vt[7]  = '{"sw",      1'b1, 3'b010, 32'h4000, 32'hDEAD_BEEF, 32'h0,        32'h0,         32'hDEAD_BEEF, 4'hF, 0, 0};
    vt[8]  = '{"op111",   1'b0, 3'b111, 32'h1004, 32'h0,        32'hA5A5_0001, 32'hA5A5_0001, 32'h0,         4'h0, 0, 0};
    vt[9]  = '{"lb_pos",  1'b0, 3'b000, 32'h1000, 32'h0,        32'h0000_007F, 32'h0000_007F, 32'h0,         4'h0, 0, 0};
    vt[10] = '{"lh_pos",  1'b0, 3'b001, 32'h1002, 32'h0,        32'h7FFF_0000, 32'h0000_7FFF, 32'h0,         4'h0, 0, 0};
    vt[11] = '{"lw_mis",  1'b0, 3'b010, 32'h1001, 32'h0,        32'h1122_3344, 32'h1122_3344, 32'h0,         4'h0, 0, 0};
    vt[12] = '{"sh_mis",  1'b1, 3'b001, 32'h2003, 32'h0000_ABCD, 32'h0,        32'h0,         32'hABCD_ABCD, 4'hC, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_state", {busy, done, fault, avalid, bwrite, bready, bwstrb, baddr, bwdata, rdata}, 106'd0);
    chk("reset_state2", {busy2, done2, fault2, avalid2, bready2, rdata2}, 37'd0);
    rst = 0;

    // Directed vectors, issued back to back
    for (int i = 0; i < 13; i++)
      do_txn(vt[i].nm, vt[i].wr, vt[i].op, vt[i].addr, vt[i].wdata, vt[i].word,
             vt[i].exp_r, vt[i].exp_bw, vt[i].exp_s, vt[i].adly, vt[i].bdly);

    // Randomized accesses against the model
    for (int i = 0; i < 40; i++) begin
      logic        r_wr;
      logic [2:0]  r_op;
      logic [31:0] r_a, r_w, r_word;
      r_wr   = 1'($urandom_range(0, 1));
      r_op   = 3'($urandom_range(0, 7));
      r_a    = $urandom;
      r_w    = $urandom;
      r_word = $urandom;
      do_txn("rand", r_wr, r_op, r_a, r_w, r_word, m_load(r_op, r_a, r_word),
             m_wdata(r_op, r_w), m_strb(r_wr, r_op, r_a),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of RESP
    $display("txn rst_mid_resp op=2 addr=00005000");
    req = 1; wv = 0; op = 3'b010; addr = 32'h5000;
    @(negedge clk);
    req = 0; aready = 1;
    @(negedge clk);
    aready = 0;
    chk("rst_in_resp", {busy, bready}, 2'b11);
    rst = 1;
    #1;
    mdl_rdata = 0;
    chk("rst_async_outputs", {busy, done, fault, avalid, bwrite, bready, bwstrb, baddr, bwdata, rdata}, 106'd0);
    @(negedge clk);
    rst = 0; bvalid = 1; brdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bvalid = 0;
    chk("rst_no_done", {busy, avalid, bready, done, fault}, 5'b00000);
    chk("rst_rdata", rdata, mdl_rdata);

    // Timeout DUT: response in the limit cycle wins, then abort, then recovery
    t2_txn("to_win", TO2, 32'hCAFE_F00D);
    t2_txn("to_abort", 0, 32'h0BAD_0BAD);
    chk("to_bready_idle", bready2, 1'b0);
    bvalid2 = 1; brdata2 = 32'hDEAD_DEAD;
    @(negedge clk);
    bvalid2 = 0;
    chk("to_late_ignored", {busy2, done2, fault2}, 3'b000);
    chk("to_late_rdata", rdata2, mdl_rdata2);
    t2_txn("to_next", 2, 32'h1234_5678);
    @(negedge clk);
    chk("to_single_done", {busy2, done2, fault2}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
